// File: rtl/tc_queue_pkg.sv
// Library-wide defaults for the TC queue component.
package tc_queue_pkg;
  localparam int DEFAULT_BIT_WIDTH = 8;
  localparam int DEFAULT_DEPTH     = 16;
endpackage

// File: rtl/tc_queue_mem.sv
// Storage array for tc_queue: one synchronous write port, one asynchronous read port.
module tc_queue_mem #(
  parameter int BIT_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BIT_WIDTH-1:0]  wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BIT_WIDTH-1:0]  rdata
);

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  // Storage is never reset; stale contents cannot reach the queue output.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tc_queue.sv
// Elastic FIFO between a fixed-latency pipeline and a stalling consumer; out is zero unless a word is delivered.
module tc_queue
  import tc_queue_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [BIT_WIDTH-1:0]         in,
  input  logic                         pop,
  output logic [BIT_WIDTH-1:0]         out,
  output logic                         out_valid,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [BIT_WIDTH-1:0]  head_data;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  // A pop on a full queue frees the slot the simultaneous push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  tc_queue_mem #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (do_push),
    .waddr(wr_ptr),
    .wdata(in),
    .raddr(rd_ptr),
    .rdata(head_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out       <= head_data;
        out_valid <= 1'b1;
      end else begin
        out       <= '0;
        out_valid <= 1'b0;
      end
      if (do_push && !do_pop) begin
        count <= count + COUNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - COUNT_ONE;
      end
      // Error flags are sticky until the next reset.
      if (push && !do_push) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tc_queue.sv
// Directed and randomized checks of tc_queue (DEPTH=4) against a queue-based reference model.
module tb_tc_queue;

  localparam int BW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic [BW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] model_q[$];
  logic [BW-1:0] exp_out = '0;
  logic          exp_valid = 1'b0;
  logic          exp_overflow = 1'b0;
  logic          exp_underflow = 1'b0;

  tc_queue #(.BIT_WIDTH(BW), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .in       (data_in),
    .pop      (pop),
    .out      (dout),
    .out_valid(dout_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Every observable output is compared with the model after each step.
  task automatic check_output();
    check_value("out",       32'(dout),       32'(exp_out));
    check_value("out_valid", 32'(dout_valid), 32'(exp_valid));
    check_value("count",     32'(count),      model_q.size());
    check_value("full",      32'(full),       32'(model_q.size() == DP));
    check_value("empty",     32'(empty),      32'(model_q.size() == 0));
    check_value("overflow",  32'(overflow),   32'(exp_overflow));
    check_value("underflow", 32'(underflow),  32'(exp_underflow));
  endtask

  task automatic apply_stimulus(input logic p, input logic q, input logic [BW-1:0] d);
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    pop_ok  = q && (model_q.size() > 0);
    push_ok = p && ((model_q.size() < DP) || pop_ok);
    exp_out   = '0;
    exp_valid = 1'b0;
    if (pop_ok) begin
      exp_out   = model_q.pop_front();
      exp_valid = 1'b1;
    end
    if (q && !pop_ok) exp_underflow = 1'b1;
    if (p && !push_ok) exp_overflow = 1'b1;
    if (push_ok) model_q.push_back(d);
    #1;
    check_output();
  endtask

  // Reset is raised between clock edges to exercise its asynchronous effect.
  task automatic do_reset();
    @(posedge clk);
    #2;
    push = 1'b0;
    pop  = 1'b0;
    rst  = 1'b1;
    #1;
    model_q.delete();
    exp_out       = '0;
    exp_valid     = 1'b0;
    exp_overflow  = 1'b0;
    exp_underflow = 1'b0;
    check_output();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] fill [4];
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    #3;
    check_output();
    do_reset();

    // Ordered fill, dropped push when full, then drain.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, fill[i]);
    apply_stimulus(1'b1, 1'b0, 8'h55);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);

    // Push and pop together on a full queue.
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, fill[i]);
    apply_stimulus(1'b1, 1'b1, 8'h99);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);

    // Push and pop together on an empty queue: no bypass.
    do_reset();
    apply_stimulus(1'b1, 1'b1, 8'hAB);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);

    // Reset with data queued discards everything.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, fill[i]);
    do_reset();

    // Streaming at count=2 for three full pointer laps.
    apply_stimulus(1'b1, 1'b0, 8'd0);
    apply_stimulus(1'b1, 1'b0, 8'd1);
    for (int i = 2; i < 2 + 3 * DP; i++) apply_stimulus(1'b1, 1'b1, 8'(i));
    apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);

    // Random traffic, with periodic resets so sticky flags can be seen again.
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset();
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
